// File: rtl/issue_scoreboard_if.sv
// Decoder/writeback/scoreboard bundle: instruction request, writeback strobes and scoreboard status.
// master = decoder and execution-unit side, slave = scoreboard side.
interface issue_scoreboard_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [14:0] src_reg;
  logic [2:0]  src_use;
  logic [2:0]  src_float;
  logic [4:0]  dst_reg;
  logic        dst_general;
  logic        dst_float;
  logic        serialize;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_reg;
  logic [1:0]  wb_float;
  logic        flush;
  logic        issue_fire;
  logic [3:0]  pending_count;
  logic [31:0] busy_gpr;
  logic [31:0] busy_fpr;
  logic [31:0] stall_cycles;

  modport master (
    output inst_valid, src_reg, src_use, src_float, dst_reg, dst_general, dst_float,
           serialize, wb_valid, wb_reg, wb_float, flush,
    input  inst_ready, issue_fire, pending_count, busy_gpr, busy_fpr, stall_cycles
  );

  modport slave (
    input  inst_valid, src_reg, src_use, src_float, dst_reg, dst_general, dst_float,
           serialize, wb_valid, wb_reg, wb_float, flush,
    output inst_ready, issue_fire, pending_count, busy_gpr, busy_fpr, stall_cycles
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard: pending GPR/FPR writes, RAW/WAW, capacity and serialize stalls.
// Zero-cycle issue; inst_ready is combinational from registered state and current inputs.
module issue_scoreboard #(
  parameter int MAX_PENDING = 8,
  parameter bit WB_BYPASS   = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  issue_scoreboard_if.slave sb_if
);
  typedef enum logic [0:0] {RUN, DRAIN} state_e;

  localparam logic [3:0] MaxCnt = 4'(MAX_PENDING);

  state_e      state_q, state_d;
  logic [31:0] busy_gpr_q, busy_gpr_d;
  logic [31:0] busy_fpr_q, busy_fpr_d;
  logic [3:0]  pend_q, pend_d;
  logic [31:0] stall_q, stall_d;

  logic [31:0] wb_hit_gpr, wb_hit_fpr;
  logic [31:0] clr_gpr, clr_fpr;
  logic [31:0] eff_gpr, eff_fpr;
  logic [31:0] set_gpr, set_fpr;
  logic [1:0]  n_clr;
  logic [4:0]  cnt_up, cnt_net;
  logic        raw, waw, writes_gpr, writes_dst, cap_stall, ser_block;
  logic        ready, fire;

  // GPR 0 writebacks never hit, so GPR 0 can never be cleared or become busy.
  always_comb begin
    wb_hit_gpr = '0;
    wb_hit_fpr = '0;
    for (int p = 0; p < 2; p++) begin
      if (sb_if.wb_valid[p]) begin
        if (sb_if.wb_float[p]) begin
          wb_hit_fpr[sb_if.wb_reg[p*5 +: 5]] = 1'b1;
        end else if (sb_if.wb_reg[p*5 +: 5] != 5'd0) begin
          wb_hit_gpr[sb_if.wb_reg[p*5 +: 5]] = 1'b1;
        end
      end
    end
  end

  assign clr_gpr = wb_hit_gpr & busy_gpr_q;
  assign clr_fpr = wb_hit_fpr & busy_fpr_q;
  assign n_clr   = 2'($countones(clr_gpr) + $countones(clr_fpr));
  assign eff_gpr = WB_BYPASS ? (busy_gpr_q & ~clr_gpr) : busy_gpr_q;
  assign eff_fpr = WB_BYPASS ? (busy_fpr_q & ~clr_fpr) : busy_fpr_q;

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_if.src_use[i]) begin
        if (sb_if.src_float[i]) begin
          raw = raw | eff_fpr[sb_if.src_reg[i*5 +: 5]];
        end else begin
          raw = raw | eff_gpr[sb_if.src_reg[i*5 +: 5]];
        end
      end
    end
  end

  // Float destination takes precedence if both destination flags are raised.
  assign writes_gpr = sb_if.dst_general && !sb_if.dst_float && (sb_if.dst_reg != 5'd0);
  assign writes_dst = sb_if.dst_float || writes_gpr;
  assign waw        = sb_if.dst_float ? eff_fpr[sb_if.dst_reg]
                                      : (writes_gpr && eff_gpr[sb_if.dst_reg]);
  assign cap_stall  = writes_dst && (pend_q == MaxCnt);
  assign ser_block  = sb_if.serialize && ((pend_q != 4'd0) || (|sb_if.wb_valid));

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      RUN: begin
        ready = !raw && !waw && !cap_stall && !ser_block;
        if (sb_if.inst_valid && sb_if.serialize && (pend_q != 4'd0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pend_q == 4'd0) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (sb_if.flush) begin
      ready   = 1'b0;
      state_d = RUN;
    end
    if (rst_i) begin
      ready = 1'b0;
    end
  end

  assign fire    = sb_if.inst_valid && ready;
  assign set_gpr = (fire && writes_gpr) ? (32'd1 << sb_if.dst_reg) : 32'd0;
  assign set_fpr = (fire && sb_if.dst_float) ? (32'd1 << sb_if.dst_reg) : 32'd0;

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_gpr_d = sb_if.flush ? 32'd0 : ((busy_gpr_q & ~clr_gpr) | set_gpr);
    busy_fpr_d = sb_if.flush ? 32'd0 : ((busy_fpr_q & ~clr_fpr) | set_fpr);
    cnt_up     = {1'b0, pend_q} + {4'd0, fire && writes_dst};
    cnt_net    = cnt_up - {3'd0, n_clr};
    if (sb_if.flush || (cnt_up < {3'd0, n_clr})) begin
      pend_d = 4'd0;
    end else if (cnt_net > {1'b0, MaxCnt}) begin
      pend_d = MaxCnt;
    end else begin
      pend_d = cnt_net[3:0];
    end
    stall_d = stall_q;
    if (sb_if.inst_valid && !ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      busy_gpr_q <= '0;
      busy_fpr_q <= '0;
      pend_q     <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_gpr_q <= busy_gpr_d;
      busy_fpr_q <= busy_fpr_d;
      pend_q     <= pend_d;
      stall_q    <= stall_d;
    end
  end

  assign sb_if.inst_ready    = ready;
  assign sb_if.issue_fire    = fire;
  assign sb_if.pending_count = pend_q;
  assign sb_if.busy_gpr      = busy_gpr_q;
  assign sb_if.busy_fpr      = busy_fpr_q;
  assign sb_if.stall_cycles  = stall_q;
endmodule
